bcd_display_mux: RTL and testbench
==================================

// Module: bcd_display_mux
// PURPOSE
//   Downstream stage of the binary-to-BCD decoder: takes its two BCD digits (out1 = tens, out0 = units).
//   Drives a 2-digit multiplexed 7-segment display with time-division scanning.
//   Latches both digits once per scan frame so the display never tears mid-frame.
//   Maps each digit to a segment pattern and drives one anode at a time.
// PARAMETERS
//   REFRESH_DIV  4  clock cycles each digit stays lit; legal range >= 2; prescaler width $clog2(REFRESH_DIV)
// PORTS
//   clk     in   1  system clock, rising edge; the only clock
//   reset   in   1  asynchronous, active-high reset
//   en      in   1  1 = scan/display; 0 = display dark, scan frozen
//   digit0  in   4  units BCD digit (from decoder out0)
//   digit1  in   4  tens BCD digit (from decoder out1)
//   seg     out  7  segments {g,f,e,d,c,b,a}, active-high, registered
//   an      out  2  anode enables, active-low, registered; an[0] = units, an[1] = tens
// BEHAVIOUR
//   Reset values (async, immediate): state = DIG0, prescaler = 0, shadow0 = shadow1 = 0,
//     an = 2'b10, seg = 7'b0111111 (glyph "0").
//   Prescaler counts 0..REFRESH_DIV-1 while en = 1; tick = (cnt == REFRESH_DIV-1); on tick, cnt -> 0.
//   FSM: two states, DIG0 and DIG1. Each tick moves DIG0 -> DIG1 or DIG1 -> DIG0. No other transitions.
//   Frame latch: on the DIG1 -> DIG0 tick, shadow0/shadow1 <= digit0/digit1.
//     The same edge drives seg from the newly captured digit0 (no one-frame lag for units).
//   seg/an are registers updated on the same edge as the state, so they always match the current state.
//     DIG0: an = 2'b10, seg = glyph(shadow0).
//     DIG1: an = 2'b01, seg = glyph(shadow1).
//   Each digit is lit for exactly REFRESH_DIV cycles; frame period = 2*REFRESH_DIV cycles.
//   Glyph table: 0:0111111  1:0000110  2:1011011  3:1001111  4:1100110
//     5:1101101  6:1111101  7:0000111  8:1111111  9:1101111
//     10..15 (invalid BCD): 1000000 (dash, segment g only).
//   en = 0:
//     next edge: an = 2'b11, seg = 0; prescaler and state hold.
//     shadows load digit0/digit1 every cycle while en = 0.
//   en 0 -> 1: next edge restores an/seg for the held state, from the current shadows; counting resumes from the held cnt.
//   Digit inputs changing outside the DIG1 -> DIG0 edge (or en = 0) have no effect until the next frame latch.
//   Reset mid-frame: immediate return to the reset values; the frame restarts in DIG0 with shadows = 0.
//     The first real digit capture happens at the first DIG1 -> DIG0 tick after reset, 2*REFRESH_DIV edges later.
//   No combinational path from any input to seg/an.
// CONFIGURATION
//   LEADING_ZERO_BLANK_EN defined:
//     in DIG1 with shadow1 == 0: an = 2'b11, seg = 7'b0000000 (tens blank); the slot length is unchanged.
//     Units are never blanked, so value 0 shows "0" on units only.
//   LEADING_ZERO_BLANK_EN undefined: tens digit 0 displays glyph "0" like any other digit.
// TESTING  (REFRESH_DIV = 4)
//   Reset asserted mid-DIG1 -> an = 2'b10, seg = 0111111 immediately, without waiting for a clock edge.
//   digit1 = 2, digit0 = 7, en = 1:
//     after the first DIG1 -> DIG0 tick, an = 10 / seg = 0000111 for 4 cycles,
//     then an = 01 / seg = 1011011 for 4 cycles, repeating.
//   Change digit0 7 -> 3 during DIG1 -> seg keeps showing 7-frame data until the DIG1 -> DIG0 edge, then 1001111.
//   digit0 = 4'hB -> units slot shows seg = 1000000.
//   en = 0 for 10 cycles -> an = 11, seg = 0 from the next edge;
//     after en = 1, the same state resumes and the slot completes its remaining cycles.
//   With LEADING_ZERO_BLANK_EN: digit1 = 0, digit0 = 5 -> tens slot an = 11, seg = 0; units slot seg = 1101101.
//     Without the macro: tens slot seg = 0111111.

Source files
------------

// File: rtl/bcd_display_mux_if.sv
// ---------------------------------------------------------------------------
// bcd_display_mux_if
//   Bundles the digit/enable inputs and the segment/anode outputs of the
//   2-digit multiplexed 7-segment driver.
//   Signals:
//     en      enable scanning (1) or dark/frozen display (0)
//     digit0  units BCD digit
//     digit1  tens BCD digit
//     seg     segments {g,f,e,d,c,b,a}, active-high
//     an      anode enables, active-low; an[0] = units, an[1] = tens
//   Modports:
//     master  the side that supplies digits/enable and watches the display
//     slave   the display driver itself
// ---------------------------------------------------------------------------
interface bcd_display_mux_if;
  logic       en;
  logic [3:0] digit0;
  logic [3:0] digit1;
  logic [6:0] seg;
  logic [1:0] an;

  modport master (
    output en,
    output digit0,
    output digit1,
    input  seg,
    input  an
  );

  modport slave (
    input  en,
    input  digit0,
    input  digit1,
    output seg,
    output an
  );
endinterface

// File: rtl/bcd_display_mux.sv
// ---------------------------------------------------------------------------
// bcd_display_mux
//   Time-division scanner for a 2-digit multiplexed 7-segment display fed by
//   a binary-to-BCD decoder. Both digits are latched once per scan frame (on
//   the tens -> units transition) so a frame never shows mixed data.
//
//   Ports:
//     clk    system clock, rising edge
//     reset  asynchronous, active-high reset
//     bus    bcd_display_mux_if.slave: en, digit0, digit1 in; seg, an out
//
//   Parameters:
//     REFRESH_DIV  clock cycles each digit stays lit (>= 2)
//
//   Build option:
//     LEADING_ZERO_BLANK_EN  when defined, a tens digit of 0 is blanked
//                            (anodes off) for its whole slot.
// ---------------------------------------------------------------------------
module bcd_display_mux #(
  parameter int REFRESH_DIV = 4
) (
  input  logic              clk,
  input  logic              reset,
  bcd_display_mux_if.slave  bus
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

  typedef enum logic {
    DIG0 = 1'b0,
    DIG1 = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       shadow0_q, shadow0_d;
  logic [3:0]       shadow1_q, shadow1_d;
  logic [6:0]       seg_q, seg_d;
  logic [1:0]       an_q, an_d;
  logic             tick;

  function automatic logic [6:0] glyph(input logic [3:0] d);
    logic [6:0] g;
    case (d)
      4'd0:    g = 7'b0111111;
      4'd1:    g = 7'b0000110;
      4'd2:    g = 7'b1011011;
      4'd3:    g = 7'b1001111;
      4'd4:    g = 7'b1100110;
      4'd5:    g = 7'b1101101;
      4'd6:    g = 7'b1111101;
      4'd7:    g = 7'b0000111;
      4'd8:    g = 7'b1111111;
      4'd9:    g = 7'b1101111;
      default: g = 7'b1000000;  // invalid BCD: dash
    endcase
    return g;
  endfunction

  assign tick = (cnt_q == CNT_MAX);

  always_comb begin
    cnt_d     = cnt_q;
    state_d   = state_q;
    shadow0_d = shadow0_q;
    shadow1_d = shadow1_q;
    an_d      = an_q;
    seg_d     = seg_q;

    if (bus.en) begin
      if (tick) begin
        cnt_d   = '0;
        state_d = (state_q == DIG0) ? DIG1 : DIG0;
        // Frame boundary: capture both digits together.
        if (state_q == DIG1) begin
          shadow0_d = bus.digit0;
          shadow1_d = bus.digit1;
        end
      end else begin
        cnt_d = cnt_q + 1'b1;
      end

      // Outputs are derived from the next state and next shadows, so the
      // units slot shows the freshly captured digit on the very edge it is
      // latched, and an en 0->1 edge restores the display for the held state.
      if (state_d == DIG0) begin
        an_d  = 2'b10;
        seg_d = glyph(shadow0_d);
      end else begin
        an_d  = 2'b01;
        seg_d = glyph(shadow1_d);
`ifdef LEADING_ZERO_BLANK_EN
        if (shadow1_d == 4'd0) begin
          an_d  = 2'b11;
          seg_d = 7'b0000000;
        end
`endif
      end
    end else begin
      // Dark and frozen: shadows keep tracking the inputs so resuming shows
      // current data without waiting for a full frame.
      an_d      = 2'b11;
      seg_d     = 7'b0000000;
      shadow0_d = bus.digit0;
      shadow1_d = bus.digit1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= DIG0;
      cnt_q     <= '0;
      shadow0_q <= 4'd0;
      shadow1_q <= 4'd0;
      an_q      <= 2'b10;
      seg_q     <= 7'b0111111;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shadow0_q <= shadow0_d;
      shadow1_q <= shadow1_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
    end
  end

  assign bus.seg = seg_q;
  assign bus.an  = an_q;

endmodule

// File: tb/tb_bcd_display_mux.sv
// ---------------------------------------------------------------------------
// tb_bcd_display_mux
//   Self-checking bench for bcd_display_mux (REFRESH_DIV = 4). The reference
//   model tracks a single frame-position counter (0 .. 2*DIV-1) plus the two
//   latched digits, and derives the expected anode/segment pattern from them.
// ---------------------------------------------------------------------------
module tb_bcd_display_mux;
  localparam int DIV = 4;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  bcd_display_mux_if bus_if ();

  bcd_display_mux #(.REFRESH_DIV(DIV)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int n_txn = 0;

  // reference model state
  int         m_pos;
  logic [3:0] m_sh0, m_sh1;
  bit         m_dark;

  logic [6:0] glyph_tab [0:9] = '{7'b0111111, 7'b0000110, 7'b1011011,
                                  7'b1001111, 7'b1100110, 7'b1101101,
                                  7'b1111101, 7'b0000111, 7'b1111111,
                                  7'b1101111};

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [6:0] ref_glyph(input logic [3:0] d);
    if (d > 4'd9) return 7'b1000000;
    return glyph_tab[d];
  endfunction

  function automatic logic [1:0] exp_an();
    if (m_dark) return 2'b11;
    if (m_pos < DIV) return 2'b10;
`ifdef LEADING_ZERO_BLANK_EN
    if (m_sh1 == 4'd0) return 2'b11;
`endif
    return 2'b01;
  endfunction

  function automatic logic [6:0] exp_seg();
    if (m_dark) return 7'b0000000;
    if (m_pos < DIV) return ref_glyph(m_sh0);
`ifdef LEADING_ZERO_BLANK_EN
    if (m_sh1 == 4'd0) return 7'b0000000;
`endif
    return ref_glyph(m_sh1);
  endfunction

  task automatic model_reset();
    m_pos  = 0;
    m_sh0  = 4'd0;
    m_sh1  = 4'd0;
    m_dark = 1'b0;
  endtask

  // One clock edge: advance the model with the inputs present at the edge,
  // then compare just after the edge.
  task automatic step(input string tag);
    @(posedge clk);
    if (reset) begin
      model_reset();
    end else if (bus_if.en) begin
      m_pos  = (m_pos + 1) % (2 * DIV);
      m_dark = 1'b0;
      if (m_pos == 0) begin
        m_sh0 = bus_if.digit0;
        m_sh1 = bus_if.digit1;
      end
    end else begin
      m_dark = 1'b1;
      m_sh0  = bus_if.digit0;
      m_sh1  = bus_if.digit1;
    end
    #1;
    n_txn++;
    $display("txn %0d %s en=%0b d1=%0h d0=%0h an=%b seg=%b", n_txn, tag,
             bus_if.en, bus_if.digit1, bus_if.digit0, bus_if.an, bus_if.seg);
    check({tag, "_an"}, 32'(bus_if.an), 32'(exp_an()));
    check({tag, "_seg"}, 32'(bus_if.seg), 32'(exp_seg()));
  endtask

  // Asynchronous reset asserted between edges; outputs must change at once.
  task automatic async_reset(input string tag);
    reset = 1'b1;
    #1;
    model_reset();
    check({tag, "_imm_an"}, 32'(bus_if.an), 32'(2'b10));
    check({tag, "_imm_seg"}, 32'(bus_if.seg), 32'(7'b0111111));
    step({tag, "_hold"});
    reset = 1'b0;
  endtask

  initial begin
    model_reset();
    reset         = 1'b0;
    bus_if.en     = 1'b0;
    bus_if.digit0 = 4'd0;
    bus_if.digit1 = 4'd0;
    #1;
    reset = 1'b1;
    #1;
    check("reset_an", 32'(bus_if.an), 32'(2'b10));
    check("reset_seg", 32'(bus_if.seg), 32'(7'b0111111));
    step("rst");
    reset = 1'b0;

    // digits 2/7 scanning
    bus_if.digit1 = 4'd2;
    bus_if.digit0 = 4'd7;
    bus_if.en     = 1'b1;
    repeat (24) step("d27");

    // change units during the tens slot: no effect until frame edge
    for (int i = 0; i < 2 * DIV && m_pos < DIV; i++) step("to_dig1");
    bus_if.digit0 = 4'd3;
    repeat (12) step("d23");

    // invalid BCD on units
    bus_if.digit0 = 4'hB;
    repeat (16) step("d2b");

    // dark for 10 cycles, then resume
    for (int i = 0; i < 2 * DIV && m_pos != 2; i++) step("to_mid");
    bus_if.en = 1'b0;
    repeat (10) step("dark");
    bus_if.en = 1'b1;
    repeat (16) step("resume");

    // leading zero on tens
    bus_if.digit1 = 4'd0;
    bus_if.digit0 = 4'd5;
    repeat (16) step("d05");

    // reset in the middle of the tens slot
    bus_if.digit1 = 4'd9;
    bus_if.digit0 = 4'd1;
    for (int i = 0; i < 2 * DIV && m_pos < DIV + 1; i++) step("to_dig1b");
    async_reset("midrst");
    repeat (20) step("post_rst");

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) bus_if.digit0 = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) bus_if.digit1 = 4'($urandom_range(0, 15));
      bus_if.en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 99) == 0) async_reset("rnd_rst");
      else step("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
